// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: a small word FIFO feeding a start/data/parity/stop serialiser
// whose bit period comes from a runtime prescaler latched at the start of each frame.
module uart_tx_param #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      DATA_VALID,
   output logic                      DATA_READY,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      STOP2,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   output logic                      S_DATA,
   output logic                      Busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // Handshake: a word is accepted on a rising edge where DATA_VALID and DATA_READY are both
   // high; DATA_READY depends only on FIFO occupancy and never on DATA_VALID.

   // ---------------------------------------------------------------- FIFO
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  pop_req;
   logic [DATA_WIDTH-1:0] head;

   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign DATA_READY = ~full;
   assign push       = DATA_VALID & ~full & ~RST;
   assign pop        = pop_req & ~empty & ~RST;
   assign head       = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= P_DATA;
      end
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------- serialiser
   logic [2:0]                state;
   logic [PRESCALE_WIDTH-1:0] period;
   logic [PRESCALE_WIDTH-1:0] tick_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic                      stop_cnt;
   logic [DATA_WIDTH-1:0]     shift;
   logic                      par_en_l;
   logic                      stop2_l;
   logic                      par_bit;
   logic [PRESCALE_WIDTH-1:0] period_next;
   logic                      bit_end;
   logic                      frame_end;

   assign period_next = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
   assign bit_end     = (tick_cnt == period - PRESCALE_WIDTH'(1));
   assign frame_end   = (state == STOP) & bit_end & (~stop2_l | stop_cnt);
   // Popping at the end of the last stop bit chains frames with no idle gap.
   assign pop_req     = (state == IDLE) | frame_end;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         S_DATA   <= 1'b1;
         Busy     <= 1'b0;
         period   <= PRESCALE_WIDTH'(1);
         tick_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shift    <= '0;
         par_en_l <= 1'b0;
         stop2_l  <= 1'b0;
         par_bit  <= 1'b0;
      end else if (pop) begin
         shift    <= head;
         par_en_l <= PAR_EN;
         stop2_l  <= STOP2;
         par_bit  <= (^head) ^ PAR_TYP;
         period   <= period_next;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         state    <= START;
         S_DATA   <= 1'b0;
         Busy     <= 1'b1;
      end else if (state == IDLE) begin
         S_DATA <= 1'b1;
         Busy   <= 1'b0;
      end else if (!bit_end) begin
         tick_cnt <= tick_cnt + PRESCALE_WIDTH'(1);
      end else begin
         tick_cnt <= '0;
         case (state)
            START: begin
               state   <= DATA;
               S_DATA  <= shift[0];
               shift   <= shift >> 1;
               bit_cnt <= '0;
            end
            DATA: begin
               if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                  if (par_en_l) begin
                     state  <= PARITY;
                     S_DATA <= par_bit;
                  end else begin
                     state    <= STOP;
                     S_DATA   <= 1'b1;
                     stop_cnt <= 1'b0;
                  end
               end else begin
                  S_DATA  <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            PARITY: begin
               state    <= STOP;
               S_DATA   <= 1'b1;
               stop_cnt <= 1'b0;
            end
            STOP: begin
               if (stop2_l && !stop_cnt) begin
                  stop_cnt <= 1'b1;
               end else begin
                  state  <= IDLE;
                  S_DATA <= 1'b1;
                  Busy   <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               S_DATA <= 1'b1;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8-bit build and a 5-bit build driven from shared
// configuration inputs, with waveforms and frame contents written out by hand.
module tb_uart_tx_param;

   logic       clk;
   logic       rst;
   logic       par_en;
   logic       par_typ;
   logic       stop2;
   logic [7:0] prescale;

   logic [7:0] p_data;
   logic       data_valid;
   logic       data_ready;
   logic       s_data;
   logic       busy;

   logic [4:0] p_data5;
   logic       data_valid5;
   logic       data_ready5;
   logic       s_data5;
   logic       busy5;

   int vectors = 0;
   int errors  = 0;
   logic [7:0] exp_q[$];

   uart_tx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_WIDTH(8)) dut (
      .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid), .DATA_READY(data_ready),
      .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
      .S_DATA(s_data), .Busy(busy)
   );

   uart_tx_param #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .PRESCALE_WIDTH(8)) dut5 (
      .CLK(clk), .RST(rst), .P_DATA(p_data5), .DATA_VALID(data_valid5), .DATA_READY(data_ready5),
      .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
      .S_DATA(s_data5), .Busy(busy5)
   );

   // ---------------------------------------------------------------- clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic line_of(input int sel);
      return (sel != 0) ? s_data5 : s_data;
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel != 0) ? busy5 : busy;
   endfunction

   // ---------------------------------------------------------------- drivers
   // Push one word into an idle transmitter and compare the line, bit by bit, against a
   // hand-written waveform string (first character is sent first).
   task automatic send_frame(input string tag, input int sel, input logic [7:0] word,
                             input string wave, input int p_eff);
      logic obs;
      logic stable;
      logic v;
      logic all_busy;
      @(negedge clk);
      if (sel != 0) begin
         p_data5     = word[4:0];
         data_valid5 = 1'b1;
      end else begin
         p_data     = word;
         data_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      data_valid  = 1'b0;
      data_valid5 = 1'b0;
      check({tag, "_prepop"}, {30'd0, line_of(sel), busy_of(sel)}, 32'h2);
      all_busy = 1'b1;
      for (int i = 0; i < wave.len(); i++) begin
         obs    = 1'b0;
         stable = 1'b1;
         for (int k = 0; k < p_eff; k++) begin
            @(negedge clk);
            v = line_of(sel);
            if (k == 0) obs = v;
            else if (v !== obs) stable = 1'b0;
            if (busy_of(sel) !== 1'b1) all_busy = 1'b0;
         end
         check($sformatf("%s_bit%0d", tag, i), {30'd0, stable, obs},
               {30'd0, 1'b1, (wave[i] == 8'h31)});
      end
      check({tag, "_busy_frame"}, {31'd0, all_busy}, 32'd1);
      @(negedge clk);
      check({tag, "_end"}, {30'd0, line_of(sel), busy_of(sel)}, 32'h2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1;
      par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 8'd4;
      p_data = '0; data_valid = 1'b0; p_data5 = '0; data_valid5 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_8", {29'd0, s_data, busy, data_ready}, 32'h5);
      check("reset_5", {29'd0, s_data5, busy5, data_ready5}, 32'h5);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 0xA5, no parity, one stop bit
      send_frame("t1_a5", 0, 8'hA5, "0101001011", 4);

      // 0xA5 has four ones: even parity 0, odd parity 1
      par_en = 1'b1; par_typ = 1'b0;
      send_frame("t2_even", 0, 8'hA5, "01010010101", 4);
      par_typ = 1'b1;
      send_frame("t2_odd", 0, 8'hA5, "01010010111", 4);

      // two stop bits, prescale 1 and 0 give the same 11-cycle frame
      par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1; prescale = 8'd1;
      send_frame("t3_p1", 0, 8'h00, "00000000011", 1);
      prescale = 8'd0;
      send_frame("t3_p0", 0, 8'h00, "00000000011", 1);

      // 5-bit build, 10011 LSB-first, even parity over three ones = 1
      stop2 = 1'b0; par_en = 1'b1; par_typ = 1'b0; prescale = 8'd3;
      send_frame("t6_w5", 1, 8'h13, "01100111", 3);

      // back-to-back frames with the FIFO filling up
      par_en = 1'b0; stop2 = 1'b0; prescale = 8'd2;
      fork
         begin : driver
            int idx = 1;
            int guard = 0;
            int ready_low = 0;
            while (idx <= 6 && guard < 500) begin
               @(negedge clk);
               guard++;
               p_data     = 8'(idx);
               data_valid = 1'b1;
               if (data_ready) begin
                  exp_q.push_back(8'(idx));
                  idx++;
               end else begin
                  ready_low++;
               end
            end
            @(negedge clk);
            data_valid = 1'b0;
            check("t4_all_pushed", idx, 7);
            check("t4_ready_low_cycles", ready_low, 17);
         end
         begin : decoder
            logic [7:0] w;
            logic [7:0] exp_w;
            int g;
            for (int f = 0; f < 6; f++) begin
               g = 0;
               do begin
                  @(negedge clk);
                  g++;
               end while (s_data !== 1'b0 && g < 300);
               if (s_data !== 1'b0) begin
                  check($sformatf("t4_start_timeout%0d", f), 32'd0, 32'd1);
                  break;
               end
               for (int i = 0; i < 8; i++) begin
                  repeat (2) @(negedge clk);
                  w[i] = s_data;
               end
               repeat (2) @(negedge clk);
               check($sformatf("t4_stop%0d", f), {31'd0, s_data}, 32'd1);
               exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
               check($sformatf("t4_word%0d", f), {24'd0, w}, {24'd0, exp_w});
            end
         end
         begin : busy_run
            int g = 0;
            int n = 0;
            while (busy !== 1'b1 && g < 300) begin
               @(negedge clk);
               g++;
            end
            while (busy === 1'b1 && n < 1000) begin
               n++;
               @(negedge clk);
            end
            check("t4_busy_run", n, 120);
         end
      join
      repeat (4) @(negedge clk);

      // reset in the middle of the first data bit with two words still queued
      prescale = 8'd4;
      data_valid = 1'b1;
      p_data = 8'h11;
      @(negedge clk);
      p_data = 8'h22;
      @(negedge clk);
      p_data = 8'h33;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_mid_data", {30'd0, s_data, busy}, 32'h3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_after_reset", {29'd0, s_data, busy, data_ready}, 32'h5);
      begin
         int busy_cycles = 0;
         int low_cycles = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_cycles++;
            if (s_data !== 1'b1) low_cycles++;
         end
         check("t5_no_busy", busy_cycles, 0);
         check("t5_line_idle", low_cycles, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the next generation of the team's fixed 8-bit transmitter. It accepts parallel words through a valid/ready handshake into a small internal FIFO and serialises them LSB-first. Frames carry optional even/odd parity and 1 or 2 stop bits, and the bit period is set by a runtime prescaler. It sits between the system datapath (ALU/register file) and the TX pin.

Parameters:
DATA_WIDTH, 8, bits per data word (5..9 legal)
FIFO_DEPTH, 4, words buffered ahead of the serialiser (power of 2, >=2)
PRESCALE_WIDTH, 8, width of PRESCALE input

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel word to send
DATA_VALID  input  1  P_DATA valid
DATA_READY  output  1  FIFO can accept a word (= not full)
PAR_EN  input  1  1 = parity bit inserted
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  0 = one stop bit, 1 = two stop bits
PRESCALE  input  PRESCALE_WIDTH  CLK cycles per serial bit; 0 treated as 1
S_DATA  output  1  serial line, idle high
Busy  output  1  high while a frame is on the line

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). The value on RST is sampled only at the CLK rising edge.
- Reset values: S_DATA=1, Busy=0, FIFO empty, DATA_READY=1, FSM=IDLE, bit/prescale counters=0.
- While RST=1, pushes are ignored and no frame starts.
- Push: a word is written when DATA_VALID && DATA_READY at a rising edge.
- DATA_READY=0 exactly when the FIFO holds FIFO_DEPTH words. DATA_VALID while not ready has no effect; the word is not captured.
- Simultaneous push and pop in the same cycle is legal when not full: occupancy is unchanged and order is preserved.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: S_DATA=1, Busy=0. If the FIFO is non-empty, pop the head into the shift register, latch PAR_EN/PAR_TYP/STOP2/PRESCALE and compute parity, then go to START.
  - START: S_DATA=0 for one bit period, then DATA.
  - DATA: S_DATA=shift[0] and shift right each bit period, for DATA_WIDTH bit periods. Then go to PARITY if latched PAR_EN, else STOP.
  - PARITY: S_DATA = (XOR of word) XOR PAR_TYP, for one bit period. Then STOP.
  - STOP: S_DATA=1 for 1 bit period, or 2 if latched STOP2.
  - At the end of STOP: if the FIFO is non-empty, pop and go straight to START with no idle gap; else go to IDLE.
- Bit period = latched PRESCALE cycles (1 if PRESCALE=0). Configuration changes mid-frame take effect at the next frame only.
- S_DATA and Busy are registered.
- Latency: a word pushed at edge E0 into an empty FIFO with the FSM in IDLE is popped at E1. S_DATA goes low and Busy high from E1.
- Busy falls at the edge ending the last stop bit when the FIFO is empty.
- Frame length = PRESCALE*(1+DATA_WIDTH+PAR_EN+1+STOP2) cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. A count register of width clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- Reset mid-frame: at that edge the frame is abandoned, FIFO contents are discarded, and S_DATA returns to 1 immediately.

Test Plan:
1. Reset, then push 0xA5 with PRESCALE=4, PAR_EN=0, STOP2=0.
   -> S_DATA=0 for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then 1 for 4 cycles. Busy high for exactly 40 cycles.
2. 0xA5 with PAR_EN=1: PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1. Frame is 44 cycles at PRESCALE=4.
3. STOP2=1, PRESCALE=1, word 0x00 -> frame 0,0×8,1,1 (11 cycles). Busy high 11 cycles.
4. Hold DATA_VALID with FIFO_DEPTH=4 and PRESCALE=2, pushing 0x01..0x06.
   -> DATA_READY drops when the FIFO holds 4 words and rises again after the next pop.
   -> Frames are back-to-back: Busy stays high, with no idle cycle between the stop bit and the next start bit.
   -> Bytes arrive in push order.
5. Assert RST for one cycle at the midpoint of a DATA bit with 2 words queued.
   -> Next cycle S_DATA=1, Busy=0, DATA_READY=1, and no further frames are sent.
6. PRESCALE=0 -> same waveform as PRESCALE=1. DATA_WIDTH=5 build, word 5'b10011, PAR_EN=1 even -> 0,1,1,0,0,1,1,1 (parity=1).
